// File: rtl/zap_mem_pkg.sv
// Shared types for the ZAP memory-align pipe: access sizes, exception bit
// positions and the width-independent sideband fields carried with each entry.
package zap_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    // Bit positions inside the 5-bit {und, iabt, swi, fiq, irq} vector.
    localparam int EXC_IRQ  = 0;
    localparam int EXC_FIQ  = 1;
    localparam int EXC_SWI  = 2;
    localparam int EXC_IABT = 3;
    localparam int EXC_UND  = 4;

    localparam int EXC_W   = 5;
    localparam int FAULT_W = 2;

    typedef struct packed {
        logic [31:0]        alu_result;
        logic [31:0]        pc_plus_8;
        logic [EXC_W-1:0]   exc;
        logic [FAULT_W-1:0] mem_fault;
        logic               load;
    } mem_side_t;

endpackage

// File: rtl/zap_load_align.sv
// Combinational load aligner: lane select, ARM misaligned-word rotate and
// zero/sign extension for 32- or 64-bit data paths in either lane order.
module zap_load_align
    import zap_mem_pkg::*;
#(
    parameter int DATA_WDT = 32
) (
    input  logic [DATA_WDT-1:0]           i_data,
    input  logic [$clog2(DATA_WDT/8)-1:0] i_addr,
    input  logic [1:0]                    i_size,
    input  logic                          i_signed,
    input  logic                          i_big_endian,
    input  logic                          i_load,
    input  logic [DATA_WDT-1:0]           i_srcdest,
    output logic [DATA_WDT-1:0]           o_data
);

    localparam int AW = $clog2(DATA_WDT/8);

    logic [AW-1:0] byte_lane;
    logic [AW-2:0] half_lane;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic [31:0]   word_val;
    logic [31:0]   word_rot;
    logic [4:0]    rot_amt;
    logic [5:0]    rot_inv;

    function automatic logic [DATA_WDT-1:0] ext_byte(input logic [7:0] b, input logic sx);
        return sx ? {{(DATA_WDT-8){b[7]}}, b} : {{(DATA_WDT-8){1'b0}}, b};
    endfunction

    function automatic logic [DATA_WDT-1:0] ext_half(input logic [15:0] h, input logic sx);
        return sx ? {{(DATA_WDT-16){h[15]}}, h} : {{(DATA_WDT-16){1'b0}}, h};
    endfunction

    // On a 64-bit path the word lane comes from a[2], mirrored in big-endian mode.
    if (DATA_WDT == 64) begin : g_word64
        assign word_val = (i_addr[AW-1] ^ i_big_endian) ? i_data[63:32] : i_data[31:0];
    end else begin : g_word32
        assign word_val = i_data[31:0];
    end

    always_comb begin
        byte_lane = i_big_endian ? ~i_addr : i_addr;
        half_lane = i_big_endian ? ~i_addr[AW-1:1] : i_addr[AW-1:1];
        byte_val  = i_data[{byte_lane, 3'b000} +: 8];
        half_val  = i_data[{half_lane, 4'b0000} +: 16];
        rot_amt   = {i_addr[1:0], 3'b000};
        rot_inv   = 6'd32 - {1'b0, rot_amt};
        // Right rotate in LE, left rotate in BE; a shift by 32 yields zero so a=0 passes through.
        if (i_big_endian) begin
            word_rot = (word_val << rot_amt) | (word_val >> rot_inv);
        end else begin
            word_rot = (word_val >> rot_amt) | (word_val << rot_inv);
        end

        o_data = i_srcdest;
        if (i_load) begin
            case (size_e'(i_size))
                SZ_BYTE:  o_data = ext_byte(byte_val, i_signed);
                SZ_HALF:  o_data = ext_half(half_val, i_signed);
                SZ_DWORD: o_data = (DATA_WDT == 64) ? i_data : DATA_WDT'(word_rot);
                default:  o_data = DATA_WDT'(word_rot);
            endcase
        end
    end

endmodule

// File: rtl/zap_memory_align_pipe.sv
// ZAP memory-stage buffer: DEPTH-entry valid/ready queue between the cache
// stage and writeback, storing load data already aligned at enqueue.
module zap_memory_align_pipe
    import zap_mem_pkg::*;
#(
    parameter int DATA_WDT = 32,
    parameter int FLAG_WDT = 32,
    parameter int PHY_REGS = 46,
    parameter int DEPTH    = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_clear,
    input  logic                          i_big_endian,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_load,
    input  logic [$clog2(DATA_WDT/8)-1:0] i_addr,
    input  logic [1:0]                    i_size,
    input  logic                          i_signed,
    input  logic [DATA_WDT-1:0]           i_rd_data,
    input  logic [DATA_WDT-1:0]           i_srcdest_value,
    input  logic [31:0]                   i_alu_result,
    input  logic [FLAG_WDT-1:0]           i_flags,
    input  logic [$clog2(PHY_REGS)-1:0]   i_dest_index,
    input  logic [$clog2(PHY_REGS)-1:0]   i_mem_index,
    input  logic [31:0]                   i_pc_plus_8,
    input  logic [4:0]                    i_exc,
    input  logic [1:0]                    i_mem_fault,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [DATA_WDT-1:0]           o_rd_data,
    output logic [31:0]                   o_alu_result,
    output logic [FLAG_WDT-1:0]           o_flags,
    output logic [$clog2(PHY_REGS)-1:0]   o_dest_index,
    output logic [$clog2(PHY_REGS)-1:0]   o_mem_index,
    output logic [31:0]                   o_pc_plus_8,
    output logic [4:0]                    o_exc,
    output logic [1:0]                    o_mem_fault,
    output logic                          o_load,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
);

    localparam int IDX_W = $clog2(PHY_REGS);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DATA_WDT-1:0] rd_data;
        logic [FLAG_WDT-1:0] flags;
        logic [IDX_W-1:0]    dest_index;
        logic [IDX_W-1:0]    mem_index;
        mem_side_t           side;
    } entry_t;

    logic [DATA_WDT-1:0] aligned_data;
    entry_t              push_entry;
    entry_t              head;
    entry_t              mem_q [DEPTH];
    entry_t              mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push;
    logic                pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    zap_load_align #(
        .DATA_WDT (DATA_WDT)
    ) u_align (
        .i_data       (i_rd_data),
        .i_addr       (i_addr),
        .i_size       (i_size),
        .i_signed     (i_signed),
        .i_big_endian (i_big_endian),
        .i_load       (i_load),
        .i_srcdest    (i_srcdest_value),
        .o_data       (aligned_data)
    );

    always_comb begin
        push_entry                 = '0;
        push_entry.rd_data         = aligned_data;
        push_entry.flags           = i_flags;
        push_entry.dest_index      = i_dest_index;
        push_entry.mem_index       = i_mem_index;
        push_entry.side.alu_result = i_alu_result;
        push_entry.side.pc_plus_8  = i_pc_plus_8;
        push_entry.side.exc        = i_exc;
        push_entry.side.mem_fault  = i_mem_fault;
        push_entry.side.load       = i_load;
    end

    // A same-cycle pop frees the head slot, so a full queue still accepts when i_ready is high.
    assign o_valid = (count_q != '0);
    assign o_ready = (count_q < CNT_W'(DEPTH)) || i_ready;
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ---- queue state register boundary ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Storage is never reset, so the exception and fault outputs are gated by o_valid.
    assign head         = mem_q[rd_ptr_q];
    assign o_rd_data    = head.rd_data;
    assign o_alu_result = head.side.alu_result;
    assign o_flags      = head.flags;
    assign o_dest_index = head.dest_index;
    assign o_mem_index  = head.mem_index;
    assign o_pc_plus_8  = head.side.pc_plus_8;
    assign o_load       = head.side.load;
    assign o_exc        = o_valid ? head.side.exc : '0;
    assign o_mem_fault  = o_valid ? head.side.mem_fault : '0;
    assign o_count      = count_q;

endmodule
